// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the multi-chip-select SPI master:
//   - spi_state_e : transfer FSM states (IDLE, SETUP, SHIFT, HOLD)
//   - CPOL_BIT / CPHA_BIT : bit positions inside the 2-bit mode word
//   - DEF_* : default values for the top-level parameters
//   - clog2_min1() : $clog2 that never returns less than 1, for port widths
// No ports (package).
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

    localparam int CPOL_BIT     = 1;
    localparam int CPHA_BIT     = 0;

    localparam int DEF_DIV_COEF = 0;
    localparam int DEF_MAX_BITS = 32;
    localparam int DEF_NCS      = 4;

    // Width helper: a one-value range still needs a 1-bit signal.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// -----------------------------------------------------------------------------
// spi_clkgen
// Generates SCK for the SPI master. While enable is high, SCK toggles once
// every H = DIV_COEF+1 clk cycles; while enable is low SCK rests at cpol.
// lead_edge / trail_edge are single-cycle strobes asserted in the cycle whose
// rising clk edge produces a leading (away from CPOL) or trailing (back to
// CPOL) SCK transition.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   enable            : run SCK (high only while shifting)
//   cpol              : SCK idle level
//   sck               : registered SCK output
//   lead_edge         : leading edge occurs at the next clk edge
//   trail_edge        : trailing edge occurs at the next clk edge
// -----------------------------------------------------------------------------
module spi_clkgen
    import spi_pkg::*;
#(
    parameter int DIV_COEF = DEF_DIV_COEF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic cpol,
    output logic sck,
    output logic lead_edge,
    output logic trail_edge
);

    localparam int CW = clog2_min1(DIV_COEF + 1);
    localparam logic [CW-1:0] TICK_AT = CW'(DIV_COEF);

    logic [CW-1:0] r_cnt;
    logic          r_sck;
    logic          w_tick;

    assign w_tick     = enable && (r_cnt == TICK_AT);
    assign lead_edge  = w_tick && (r_sck == cpol);
    assign trail_edge = w_tick && (r_sck != cpol);
    assign sck        = r_sck;

    // Half-period counter and SCK register; SCK is parked at cpol when disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (!enable) begin
            r_cnt <= '0;
            r_sck <= cpol;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_mc.sv
// -----------------------------------------------------------------------------
// spi_master_mc
// SPI master with NCS chip selects, all four SPI modes, MSB-first transfers of
// 1..MAX_BITS bits and a programmable SCK divider (half period H = DIV_COEF+1).
// A transfer takes (2*nbits+2)*H+1 clk cycles from the accepting edge to ready.
// Optional feature macro: SPI_LOOPBACK_EN adds input `loopback`; while it is
// high the receiver samples the internal MOSI and all chip selects stay high.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   mosi_data          : transmit word, right-justified
//   miso_data          : received word, right-justified, updated when ready rises
//   nbits              : bits to transfer (0 = ignored, >MAX_BITS clamped)
//   cs_sel             : chip-select index (>=NCS maps to NCS-1)
//   mode               : {CPOL, CPHA}
//   request / ready    : start handshake / idle indicator
//   spi_sck, spi_mosi, spi_miso, spi_csn : SPI bus (csn active-low)
//   loopback           : only with SPI_LOOPBACK_EN
// -----------------------------------------------------------------------------
module spi_master_mc
    import spi_pkg::*;
#(
    parameter int DIV_COEF = DEF_DIV_COEF,
    parameter int MAX_BITS = DEF_MAX_BITS,
    parameter int NCS      = DEF_NCS
) (
    input  logic                              clk,
    input  logic                              reset,
`ifdef SPI_LOOPBACK_EN
    input  logic                              loopback,
`endif
    input  logic [MAX_BITS-1:0]               mosi_data,
    output logic [MAX_BITS-1:0]               miso_data,
    input  logic [$clog2(MAX_BITS+1)-1:0]     nbits,
    input  logic [clog2_min1(NCS)-1:0]        cs_sel,
    input  logic [1:0]                        mode,
    input  logic                              request,
    output logic                              ready,
    output logic                              spi_sck,
    output logic                              spi_mosi,
    input  logic                              spi_miso,
    output logic [NCS-1:0]                    spi_csn
);

    localparam int NBW = $clog2(MAX_BITS + 1);
    localparam int CSW = clog2_min1(NCS);
    localparam int HW  = clog2_min1(DIV_COEF + 1);

    spi_state_e        r_state;
    spi_state_e        w_state_nxt;
    logic [HW-1:0]     r_wait;
    logic              r_ready;
    logic [NCS-1:0]    r_csn;
    logic              r_mosi;
    logic [MAX_BITS-1:0] r_miso_data;
    logic [MAX_BITS-1:0] r_tx;
    logic [MAX_BITS-1:0] r_rx;
    logic [1:0]        r_mode;
    logic [NBW-1:0]    r_nbits;
    logic [NBW-1:0]    r_edge_cnt;

    logic              w_accept;
    logic              w_finish;
    logic              w_wait_done;
    logic              w_last_edge;
    logic [NBW-1:0]    w_nbits_c;
    logic [NBW-1:0]    w_shamt;
    logic [MAX_BITS-1:0] w_tx_aligned;
    logic [CSW-1:0]    w_cs_idx;
    logic              w_cpol;
    logic              w_sck;
    logic              w_lead;
    logic              w_trail;
    logic              w_miso_in;

    assign w_accept     = (r_state == IDLE) && r_ready && request && (nbits != '0);
    // Idle with ready still low: the single cycle that publishes the result.
    assign w_finish     = (r_state == IDLE) && !r_ready;
    assign w_wait_done  = (r_wait == HW'(DIV_COEF));
    assign w_last_edge  = w_trail && (r_edge_cnt == (r_nbits - NBW'(1)));
    assign w_nbits_c    = (nbits > NBW'(MAX_BITS)) ? NBW'(MAX_BITS) : nbits;
    assign w_cs_idx     = (int'(cs_sel) >= NCS) ? CSW'(NCS - 1) : cs_sel;
    // Left-justify the word so the first bit out is always the top bit.
    assign w_shamt      = NBW'(MAX_BITS) - w_nbits_c;
    assign w_tx_aligned = mosi_data << w_shamt;
    // On the accepting edge SCK must already settle to the new CPOL.
    assign w_cpol       = w_accept ? mode[CPOL_BIT] : r_mode[CPOL_BIT];

`ifdef SPI_LOOPBACK_EN
    assign w_miso_in = loopback ? r_mosi : spi_miso;
    assign spi_csn   = loopback ? {NCS{1'b1}} : r_csn;
`else
    assign w_miso_in = spi_miso;
    assign spi_csn   = r_csn;
`endif

    assign ready     = r_ready;
    assign miso_data = r_miso_data;
    assign spi_sck   = w_sck;
    assign spi_mosi  = r_mosi;

    spi_clkgen #(
        .DIV_COEF (DIV_COEF)
    ) u_clkgen (
        .clk        (clk),
        .reset      (reset),
        .enable     (r_state == SHIFT),
        .cpol       (w_cpol),
        .sck        (w_sck),
        .lead_edge  (w_lead),
        .trail_edge (w_trail)
    );

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_state_nxt = SETUP; else w_state_nxt = IDLE;
            SETUP:   if (w_wait_done) w_state_nxt = SHIFT; else w_state_nxt = SETUP;
            SHIFT:   if (w_last_edge) w_state_nxt = HOLD;  else w_state_nxt = SHIFT;
            HOLD:    if (w_wait_done) w_state_nxt = IDLE;  else w_state_nxt = HOLD;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register and SETUP/HOLD dwell counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt != r_state) || ((r_state != SETUP) && (r_state != HOLD))) begin
                r_wait <= '0;
            end else begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

    // Transfer datapath: latch on accept, shift on SCK edges, publish on finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready     <= 1'b1;
            r_csn       <= {NCS{1'b1}};
            r_mosi      <= 1'b0;
            r_miso_data <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_mode      <= 2'b00;
            r_nbits     <= '0;
            r_edge_cnt  <= '0;
        end else if (w_accept) begin
            r_ready    <= 1'b0;
            r_mode     <= mode;
            r_nbits    <= w_nbits_c;
            r_csn      <= ~(NCS'(1) << w_cs_idx);
            r_rx       <= '0;
            r_edge_cnt <= '0;
            if (!mode[CPHA_BIT]) begin
                // CPHA=0: first bit must be on the wire before the first edge.
                r_mosi <= w_tx_aligned[MAX_BITS-1];
                r_tx   <= {w_tx_aligned[MAX_BITS-2:0], 1'b0};
            end else begin
                r_mosi <= 1'b0;
                r_tx   <= w_tx_aligned;
            end
        end else if (w_finish) begin
            r_ready     <= 1'b1;
            r_csn       <= {NCS{1'b1}};
            r_miso_data <= r_rx;
            r_mosi      <= 1'b0;
        end else if (r_state == SHIFT) begin
            if (w_lead) begin
                if (!r_mode[CPHA_BIT]) begin
                    r_rx <= {r_rx[MAX_BITS-2:0], w_miso_in};
                end else begin
                    r_mosi <= r_tx[MAX_BITS-1];
                    r_tx   <= {r_tx[MAX_BITS-2:0], 1'b0};
                end
            end
            if (w_trail) begin
                r_edge_cnt <= r_edge_cnt + NBW'(1);
                if (!r_mode[CPHA_BIT]) begin
                    r_mosi <= r_tx[MAX_BITS-1];
                    r_tx   <= {r_tx[MAX_BITS-2:0], 1'b0};
                end else begin
                    r_rx <= {r_rx[MAX_BITS-2:0], w_miso_in};
                end
            end
        end
    end

endmodule
